// File: rtl/fp_arb.sv
// fp_arb: two-port round-robin arbiter and sequencer for the shared fp_exe.
// One op in flight at a time; multi-cycle ops are waited out under a watchdog.
package fp_arb_pkg;

    typedef struct packed {
        logic fmadd;
        logic fmsub;
        logic fnmadd;
        logic fnmsub;
        logic fadd;
        logic fsub;
        logic fmul;
        logic fdiv;
        logic fsqrt;
        logic fsgnj;
        logic fcmp;
        logic fmax;
        logic fclass;
        logic fmv_i2f;
        logic fmv_f2i;
        logic fcvt_f2f;
        logic fcvt_i2f;
        logic fcvt_f2i;
    } fp_operation_type;

    typedef struct packed {
        logic [63:0]      data1;
        logic [63:0]      data2;
        logic [63:0]      data3;
        fp_operation_type op;
        logic [1:0]       fmt;
        logic [2:0]       rm;
        logic             enable;
    } fp_exe_in_type;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  flags;
        logic        ready;
    } fp_exe_out_type;

    function automatic logic is_multi(input fp_operation_type op);
        return op.fmadd | op.fmsub | op.fnmadd | op.fnmsub |
               op.fadd | op.fsub | op.fmul | op.fdiv | op.fsqrt;
    endfunction

endpackage

module fp_arb
    import fp_arb_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic           clock,
    input  logic           reset,
    input  fp_exe_in_type  req0_i,
    output logic           req0_ready,
    input  fp_exe_in_type  req1_i,
    output logic           req1_ready,
    input  logic           flush,
    output fp_exe_in_type  fp_exe_i,
    input  fp_exe_out_type fp_exe_o,
    output logic           clear,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic           resp_id,
    output logic [63:0]    resp_result,
    output logic [4:0]     resp_flags,
    output logic           resp_err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state;
    state_t        state_n;
    logic          prio;
    logic [CW-1:0] cnt;
    logic          grant;
    logic          gnt_id;
    logic          multi;
    logic          expired;
    fp_exe_in_type sel;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        fp_exe_i   = '0;
        clear      = 1'b0;
        grant      = 1'b0;
        gnt_id     = 1'b0;
        multi      = 1'b0;
        expired    = 1'b0;
        sel        = '0;
        unique case (state)
            S_IDLE: begin
                if (!flush && (req0_i.enable || req1_i.enable)) begin
                    grant  = 1'b1;
                    gnt_id = (req0_i.enable && req1_i.enable)
                           ? prio : req1_i.enable;
                    sel    = gnt_id ? req1_i : req0_i;
                    multi  = is_multi(sel.op);
                    fp_exe_i        = sel;
                    fp_exe_i.enable = 1'b1;
                    req0_ready = !gnt_id;
                    req1_ready = gnt_id;
                    state_n    = multi ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    clear   = 1'b1;
                    state_n = S_IDLE;
                end else if (fp_exe_o.ready) begin
                    state_n = S_RESP;
                end else if (cnt == LAST) begin
                    // ready on the last cycle still wins over the abort
                    clear   = 1'b1;
                    expired = 1'b1;
                    state_n = S_RESP;
                end
            end
            S_RESP: begin
                if (flush || resp_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign resp_valid = (state == S_RESP);

    always_ff @(posedge clock) begin
        if (!reset) begin
            prio        <= 1'b0;
            cnt         <= '0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_flags  <= '0;
            resp_err    <= 1'b0;
        end else begin
            if (grant) begin
                prio    <= !gnt_id;
                resp_id <= gnt_id;
                cnt     <= '0;
                if (!multi) begin
                    resp_result <= fp_exe_o.result;
                    resp_flags  <= fp_exe_o.flags;
                    resp_err    <= 1'b0;
                end
            end
            if (state == S_WAIT && !flush) begin
                if (fp_exe_o.ready) begin
                    resp_result <= fp_exe_o.result;
                    resp_flags  <= fp_exe_o.flags;
                    resp_err    <= 1'b0;
                end else if (expired) begin
                    resp_result <= '0;
                    resp_flags  <= '0;
                    resp_err    <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_arb.sv
// tb_fp_arb: random requesters, fp_exe latency model and a deadline-based
// transaction model predicting grants, clears and responses per cycle.
module tb_fp_arb;
    import fp_arb_pkg::*;

    localparam int TO = 8;

    logic           clk = 1'b1;
    logic           rst_n;
    fp_exe_in_type  r0;
    fp_exe_in_type  r1;
    fp_exe_in_type  fpi;
    fp_exe_out_type fpo;
    logic           g0;
    logic           g1;
    logic           flush;
    logic           clr;
    logic           rv;
    logic           rr;
    logic           rid;
    logic           rerr;
    logic [63:0]    rres;
    logic [4:0]     rfl;

    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    fp_arb #(.TIMEOUT(TO)) dut (
        .clock      (clk),
        .reset      (rst_n),
        .req0_i     (r0),
        .req0_ready (g0),
        .req1_i     (r1),
        .req1_ready (g1),
        .flush      (flush),
        .fp_exe_i   (fpi),
        .fp_exe_o   (fpo),
        .clear      (clr),
        .resp_valid (rv),
        .resp_ready (rr),
        .resp_id    (rid),
        .resp_result(rres),
        .resp_flags (rfl),
        .resp_err   (rerr)
    );

    function automatic logic multi_op(input fp_operation_type o);
        return o.fmadd | o.fmsub | o.fnmadd | o.fnmsub | o.fadd |
               o.fsub | o.fmul | o.fdiv | o.fsqrt;
    endfunction

    function automatic logic [63:0] fres(input fp_exe_in_type x);
        return x.data1 ^ {x.data2[31:0], x.data2[63:32]} ^ {46'd0, x.op};
    endfunction

    function automatic logic [4:0] ffl(input fp_exe_in_type x);
        return x.data1[4:0] ^ x.data2[9:5] ^ {x.rm, x.fmt};
    endfunction

    // fp_exe stand-in: single ops answer in the issue cycle, multi-cycle
    // ops raise ready data3[9:0] cycles after issue unless cleared.
    logic        pend = 1'b0;
    int unsigned pend_t = 0;
    int unsigned pend_lat = 0;
    logic [63:0] pend_res = '0;
    logic [4:0]  pend_fl = '0;

    always_comb begin
        fpo        = '0;
        fpo.result = 64'hbad0_bad0_bad0_bad0;
        fpo.flags  = 5'h1f;
        if (fpi.enable && !multi_op(fpi.op)) begin
            fpo.result = fres(fpi);
            fpo.flags  = ffl(fpi);
        end else if (pend && cyc == pend_t + pend_lat) begin
            fpo.ready  = 1'b1;
            fpo.result = pend_res;
            fpo.flags  = pend_fl;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr) begin
            pend <= 1'b0;
        end else if (fpi.enable && multi_op(fpi.op)) begin
            pend     <= 1'b1;
            pend_t   <= cyc;
            pend_lat <= int'(fpi.data3[9:0]);
            pend_res <= fres(fpi);
            pend_fl  <= ffl(fpi);
        end else if (pend && fpo.ready) begin
            pend <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // stimulus knobs (percent, reset in per-mille)
    int k_new = 0;
    int k_multi = 0;
    int k_flush = 0;
    int k_rdy = 100;
    int k_rst = 0;
    bit f_rst = 1'b1;
    bit rr_log = 1'b0;

    fp_exe_in_type rq[2];
    bit            has[2] = '{1'b0, 1'b0};
    int            gq_id[$];
    int unsigned   gq_c[$];

    // model: 0 idle, 1 op in fp_exe until m_done, 2 response held
    int          ph = 0;
    int unsigned m_done = 0;
    logic        m_to = 1'b0;
    logic        m_prio = 1'b0;
    logic        m_id = 1'b0;
    logic [63:0] m_res = '0;
    logic [4:0]  m_fl = '0;
    logic        m_err = 1'b0;
    bit          just_rst = 1'b0;

    function automatic fp_exe_in_type gen(input int pm);
        fp_exe_in_type x;
        int k;
        x = '0;
        if ($urandom % 100 < pm) k = int'($urandom_range(0, 8));
        else k = int'($urandom_range(9, 17));
        x.op    = fp_operation_type'(18'd1 << (17 - k));
        x.data1 = {$urandom, $urandom};
        x.data2 = {$urandom, $urandom};
        x.data3 = {$urandom, $urandom};
        x.fmt   = 2'($urandom);
        x.rm    = 3'($urandom);
        if (k < 9) x.data3[9:0] = 10'($urandom_range(1, TO + 3));
        x.enable = 1'b1;
        return x;
    endfunction

    task automatic step();
        fp_exe_in_type x;
        fp_exe_in_type ex;
        logic xr0;
        logic xr1;
        logic xclr;
        logic gid;
        logic o0;
        logic o1;
        int unsigned lat;
        rst_n = !(f_rst || ($urandom % 1000 < k_rst));
        flush = rst_n && ($urandom % 100 < k_flush);
        rr    = ($urandom % 100 < k_rdy);
        for (int i = 0; i < 2; i++) begin
            if (!has[i] && $urandom % 100 < k_new) begin
                has[i] = 1'b1;
                rq[i]  = gen(k_multi);
            end
        end
        r0 = (rst_n && has[0]) ? rq[0] : '0;
        r1 = (rst_n && has[1]) ? rq[1] : '0;
        @(negedge clk);
        o0 = 1'b0;
        o1 = 1'b0;
        if (!rst_n) begin
            ph       = 0;
            m_prio   = 1'b0;
            just_rst = 1'b1;
        end else begin
            xr0  = 1'b0;
            xr1  = 1'b0;
            xclr = 1'b0;
            ex   = '0;
            if (just_rst) begin
                chk("rst_id", 64'(rid), 64'(0));
                chk("rst_result", rres, 64'(0));
                chk("rst_flags", 64'(rfl), 64'(0));
                chk("rst_err", 64'(rerr), 64'(0));
                just_rst = 1'b0;
            end
            chk("resp_valid", 64'(rv), 64'(ph == 2));
            if (ph == 2) begin
                chk("resp_id", 64'(rid), 64'(m_id));
                chk("resp_result", rres, m_res);
                chk("resp_flags", 64'(rfl), 64'(m_fl));
                chk("resp_err", 64'(rerr), 64'(m_err));
            end
            case (ph)
                0: begin
                    if (!flush && (r0.enable || r1.enable)) begin
                        if (r0.enable && r1.enable) gid = m_prio;
                        else gid = r1.enable;
                        x      = gid ? r1 : r0;
                        ex     = x;
                        xr0    = !gid;
                        xr1    = gid;
                        m_prio = !gid;
                        m_id   = gid;
                        if (multi_op(x.op)) begin
                            lat = int'(x.data3[9:0]);
                            m_to = (lat > TO);
                            m_done = cyc + (m_to ? TO : lat);
                            m_res = m_to ? 64'd0 : fres(x);
                            m_fl  = m_to ? 5'd0 : ffl(x);
                            m_err = m_to;
                            ph = 1;
                        end else begin
                            m_res = fres(x);
                            m_fl  = ffl(x);
                            m_err = 1'b0;
                            ph = 2;
                        end
                    end
                end
                1: begin
                    if (flush) begin
                        xclr = 1'b1;
                        ph   = 0;
                    end else if (cyc == m_done) begin
                        xclr = m_to;
                        ph   = 2;
                    end
                end
                default: begin
                    if (flush || rr) ph = 0;
                end
            endcase
            chk("req0_ready", 64'(g0), 64'(xr0));
            chk("req1_ready", 64'(g1), 64'(xr1));
            chk("clear", 64'(clr), 64'(xclr));
            chk("exe_data1", fpi.data1, ex.data1);
            chk("exe_data2", fpi.data2, ex.data2);
            chk("exe_data3", fpi.data3, ex.data3);
            chk("exe_ctl", 64'({fpi.op, fpi.fmt, fpi.rm, fpi.enable}),
                64'({ex.op, ex.fmt, ex.rm, ex.enable}));
            o0 = g0;
            o1 = g1;
            if (rr_log && (g0 || g1)) begin
                gq_id.push_back(int'(g1));
                gq_c.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        if (o0) has[0] = 1'b0;
        if (o1) has[1] = 1'b0;
    endtask

    initial begin
        r0    = '0;
        r1    = '0;
        flush = 1'b0;
        rr    = 1'b1;
        rst_n = 1'b0;
        repeat (2) step();
        f_rst = 1'b0;

        // both requesters busy with single-cycle ops straight out of reset
        k_new = 100;
        rr_log = 1'b1;
        repeat (12) step();
        rr_log = 1'b0;
        chk("rr_count", 64'(gq_id.size() >= 4), 64'(1));
        for (int i = 0; i < 4 && i < gq_id.size(); i++) begin
            chk("rr_order", 64'(gq_id[i]), 64'(i % 2));
            // accept, RESP, then the next accept in the third cycle
            if (i > 0) chk("rr_gap", 64'(gq_c[i] - gq_c[i-1]), 64'(2));
        end

        k_new = 40; k_multi = 50; k_flush = 3; k_rdy = 60; k_rst = 5;
        repeat (3000) step();

        k_flush = 0; k_rst = 0; k_rdy = 15;
        repeat (600) step();

        k_multi = 100; k_rdy = 80; k_flush = 4;
        repeat (600) step();

        f_rst = 1'b1;
        step();
        f_rst = 1'b0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
